// File: rtl/sd_card_cmd.sv
// sd_card_cmd: card-side SD CMD line responder (receive 48-bit commands, transmit R1/R2/R3/R6/R7 responses).
// Optional: define SD_CMD_CRC_CHECK_EN to verify the received CRC7; otherwise only the end bit is checked.
module sd_card_cmd #(
    parameter int unsigned NCR = 2
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         icmd,
    output logic         ocmd,
    output logic         ocmd_en,
    output logic         ocmd_valid,
    output logic [5:0]   ocmd_index,
    output logic [31:0]  ocmd_arg,
    output logic         ocmd_err,
    input  logic         iresp_valid,
    input  logic         iresp_long,
    input  logic         iresp_nocrc,
    input  logic [5:0]   iresp_index,
    input  logic [119:0] iresp_data,
    output logic         oresp_busy,
    output logic         oresp_done
);

    typedef enum logic [2:0] {IDLE, RX, CHECK, WAIT, TX} state_t;

    localparam logic [6:0] NCR_GAP  = 7'(NCR);
    localparam logic [6:0] WAIT_MAX = 7'd64;

    state_t        state;
    logic [45:0]   rx_sr;
    logic [5:0]    rx_cnt;
    logic [6:0]    gap;
    logic          pending;
    logic          lat_long;
    logic          lat_nocrc;
    logic [5:0]    lat_index;
    logic [119:0]  lat_data;
    logic [126:0]  tx_sr;
    logic [7:0]    tx_cnt;
    logic          tx_long;
    logic          tx_nocrc;
    logic [6:0]    crc;

    logic          frame_good;
    logic          accept;
    logic          go;
    logic          src_long;
    logic          src_nocrc;
    logic [5:0]    src_index;
    logic [119:0]  src_data;
    logic [7:0]    payload_end;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

`ifdef SD_CMD_CRC_CHECK_EN
    function automatic logic [6:0] crc7_bits40(input logic [39:0] m);
        logic [6:0]  c;
        logic [39:0] w;
        c = '0;
        w = m;
        for (int unsigned i = 0; i < 40; i++) begin
            c = crc7_step(c, w[39]);
            w = {w[38:0], 1'b0};
        end
        return c;
    endfunction

    // Start and transmission bits are implied (0 and 1); only bits 45..0 are stored.
    assign frame_good = rx_sr[0] && (crc7_bits40({2'b01, rx_sr[45:8]}) == rx_sr[7:1]);
`else
    assign frame_good = rx_sr[0];
`endif

    always_comb begin
        accept      = (state == WAIT) && icmd && !pending && iresp_valid;
        go          = (state == WAIT) && icmd && (pending || accept) && (gap >= NCR_GAP);
        src_long    = pending ? lat_long  : iresp_long;
        src_nocrc   = pending ? lat_nocrc : iresp_nocrc;
        src_index   = pending ? lat_index : iresp_index;
        src_data    = pending ? lat_data  : iresp_data;
        payload_end = tx_long ? 8'd128 : 8'd40;
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state      <= IDLE;
            ocmd       <= 1'b1;
            ocmd_en    <= 1'b0;
            ocmd_valid <= 1'b0;
            ocmd_err   <= 1'b0;
            ocmd_index <= '0;
            ocmd_arg   <= '0;
            oresp_busy <= 1'b0;
            oresp_done <= 1'b0;
            rx_sr      <= '0;
            rx_cnt     <= '0;
            gap        <= '0;
            pending    <= 1'b0;
            lat_long   <= 1'b0;
            lat_nocrc  <= 1'b0;
            lat_index  <= '0;
            lat_data   <= '0;
            tx_sr      <= '0;
            tx_cnt     <= '0;
            tx_long    <= 1'b0;
            tx_nocrc   <= 1'b0;
            crc        <= '0;
        end else begin
            ocmd_valid <= 1'b0;
            ocmd_err   <= 1'b0;
            oresp_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!icmd) begin
                        rx_cnt <= '0;
                        state  <= RX;
                    end
                end
                RX: begin
                    rx_sr  <= {rx_sr[44:0], icmd};
                    rx_cnt <= rx_cnt + 6'd1;
                    if (rx_cnt == 6'd0 && !icmd) begin
                        state <= IDLE;
                    end else if (rx_cnt == 6'd46) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    gap     <= 7'd2;
                    pending <= 1'b0;
                    if (frame_good) begin
                        ocmd_index <= rx_sr[45:40];
                        ocmd_arg   <= rx_sr[39:8];
                        ocmd_valid <= 1'b1;
                        state      <= WAIT;
                    end else begin
                        ocmd_err <= 1'b1;
                        state    <= IDLE;
                    end
                end
                WAIT: begin
                    gap <= gap + 7'd1;
                    if (!icmd) begin
                        pending <= 1'b0;
                        rx_cnt  <= '0;
                        state   <= RX;
                    end else begin
                        if (accept) begin
                            pending   <= 1'b1;
                            lat_long  <= iresp_long;
                            lat_nocrc <= iresp_nocrc;
                            lat_index <= iresp_index;
                            lat_data  <= iresp_data;
                        end
                        if (go) begin
                            // Start bit is registered on the same edge the frame is loaded.
                            ocmd       <= 1'b0;
                            ocmd_en    <= 1'b1;
                            oresp_busy <= 1'b1;
                            tx_cnt     <= 8'd1;
                            crc        <= '0;
                            tx_long    <= src_long;
                            tx_nocrc   <= src_nocrc;
                            tx_sr      <= src_long ? {1'b0, 6'h3F, src_data}
                                                   : {1'b0, src_index, src_data[31:0], 88'd0};
                            pending    <= 1'b0;
                            state      <= TX;
                        end else if (!pending && !accept && gap >= WAIT_MAX) begin
                            state <= IDLE;
                        end
                    end
                end
                TX: begin
                    tx_cnt <= tx_cnt + 8'd1;
                    if (tx_cnt < payload_end) begin
                        ocmd  <= tx_sr[126];
                        tx_sr <= {tx_sr[125:0], 1'b0};
                        // Long frames exclude the transmission bit and reserved ones from the CRC.
                        if (!(tx_long && tx_cnt < 8'd8)) begin
                            crc <= crc7_step(crc, tx_sr[126]);
                        end
                    end else if (tx_cnt < payload_end + 8'd7) begin
                        ocmd <= tx_nocrc | crc[6];
                        crc  <= {crc[5:0], 1'b0};
                    end else if (tx_cnt == payload_end + 8'd7) begin
                        ocmd <= 1'b1;
                    end else begin
                        ocmd       <= 1'b1;
                        ocmd_en    <= 1'b0;
                        oresp_busy <= 1'b0;
                        oresp_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
